// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Shared definitions for the double-buffered frame store. The readout datapath
// decodes the same 5-bit state codes, so they live here rather than in the
// controller.
//   frame_state_e          : 5-bit state code driven on oState
//   DEFAULT_SCREEN_WIDTH   : pixels per row used for watchdog sizing
//   DEFAULT_SCREEN_HEIGHT  : rows per frame used for watchdog sizing
// -----------------------------------------------------------------------------
package frame_pkg;

    localparam int DEFAULT_SCREEN_WIDTH  = 320;
    localparam int DEFAULT_SCREEN_HEIGHT = 240;

    typedef enum logic [4:0] {
        IDLE               = 5'd0,
        CHANGE_STATE0      = 5'd9,
        CHANGE_STATE0_LOAD = 5'd10,
        CHANGE_STATE1      = 5'd11,
        CHANGE_STATE1_LOAD = 5'd12,
        CLEAR_RESET_WAIT0  = 5'd13,
        CLEAR_RESET_SLOT0  = 5'd14,
        CLEAR_RESET_WAIT1  = 5'd15,
        CLEAR_RESET_SLOT1  = 5'd16
    } frame_state_e;

endpackage

// File: rtl/frame_swap_req_latch.sv
// -----------------------------------------------------------------------------
// frame_swap_req_latch
// Holds the swap and clear requests until the controller can serve them.
// Repeated requests merge into one pending flag. Swap wins over clear, and
// neither is served while the drawing engine is mid-primitive.
//   clk_i, reset_i      : clock, synchronous active-high reset
//   swapReq_i           : swap request pulse
//   clearReq_i          : clear request pulse
//   autoClearSet_i      : controller queues a clear after a completed swap
//   idle_i              : controller is in IDLE and can start a sequence
//   drawBusy_i          : drawing engine is mid-primitive
//   enterSwap_o         : start the swap sequence at the next edge
//   enterClear_o        : start the clear sequence at the next edge
//   swapPendNext_o      : swap pending flag value after the next edge
//   clearPendNext_o     : clear pending flag value after the next edge
// -----------------------------------------------------------------------------
module frame_swap_req_latch
    import frame_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic swapReq_i,
    input  logic clearReq_i,
    input  logic autoClearSet_i,
    input  logic idle_i,
    input  logic drawBusy_i,
    output logic enterSwap_o,
    output logic enterClear_o,
    output logic swapPendNext_o,
    output logic clearPendNext_o
);

    logic swapPend_q, swapPend_d;
    logic clearPend_q, clearPend_d;

    // A flag is consumed on the cycle its sequence starts. A request that
    // arrives in that same cycle is a new request and stays pending.
    always_comb begin
        enterSwap_o  = idle_i && swapPend_q && !drawBusy_i;
        enterClear_o = idle_i && clearPend_q && !swapPend_q && !drawBusy_i;
        swapPend_d   = swapReq_i | (swapPend_q & ~enterSwap_o);
        clearPend_d  = clearReq_i | autoClearSet_i | (clearPend_q & ~enterClear_o);
        swapPendNext_o  = swapPend_d;
        clearPendNext_o = clearPend_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            swapPend_q  <= 1'b0;
            clearPend_q <= 1'b0;
        end else begin
            swapPend_q  <= swapPend_d;
            clearPend_q <= clearPend_d;
        end
    end

endmodule

// File: rtl/frame_swap_ctrl.sv
// -----------------------------------------------------------------------------
// frame_swap_ctrl
// Sequences the double-buffered frame-store readout: swaps the displayed
// buffer after a full load and schedules clears of the back buffer. The back
// buffer is always ~oFrontBuf; the drawing engine owns it only while idle.
// Optional macro FRAME_SWAP_TIMEOUT_EN adds a watchdog on the LOAD and SLOT
// waits; without it the FSM waits indefinitely and oTimeout stays 0.
//   iClk, iReset  : clock, synchronous active-high reset
//   iSwapReq      : pulse, display the current back buffer
//   iClearReq     : pulse, clear the current back buffer
//   iDrawBusy     : drawing engine is mid-primitive
//   iLoadDone     : readout datapath finished a frame
//   iClearDone    : clear engine finished
//   oState        : current state code for the readout datapath
//   oFrontBuf     : buffer currently displayed
//   oDrawGrant    : drawing engine may start a new primitive
//   oClearStart   : one-cycle pulse starting the clear engine
//   oBusy         : FSM not in IDLE
//   oTimeout      : one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module frame_swap_ctrl
    import frame_pkg::*;
#(
    parameter int SCREEN_WIDTH   = DEFAULT_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT  = DEFAULT_SCREEN_HEIGHT,
    parameter int AUTO_CLEAR     = 1,
    parameter int TIMEOUT_CYCLES = 2*SCREEN_WIDTH*SCREEN_HEIGHT+64
)(
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iSwapReq,
    input  logic       iClearReq,
    input  logic       iDrawBusy,
    input  logic       iLoadDone,
    input  logic       iClearDone,
    output logic [4:0] oState,
    output logic       oFrontBuf,
    output logic       oDrawGrant,
    output logic       oClearStart,
    output logic       oBusy,
    output logic       oTimeout
);

    // A watchdog that fires immediately would make every sequence abort.
    if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
        $error("frame_swap_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    frame_state_e state_q, state_d;
    logic front_q, front_d;
    logic grant_q, grant_d;
    logic clearStart_q, clearStart_d;
    logic busy_q, busy_d;
    logic timeout_q, timeout_d;
    logic autoClearSet;
    logic enterSwap, enterClear, swapPendNext, clearPendNext;

`ifdef FRAME_SWAP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timer_q, timer_d;
    logic inTimedState;
`endif

    frame_swap_req_latch uReqLatch (
        .clk_i           (iClk),
        .reset_i         (iReset),
        .swapReq_i       (iSwapReq),
        .clearReq_i      (iClearReq),
        .autoClearSet_i  (autoClearSet),
        .idle_i          (state_q == IDLE),
        .drawBusy_i      (iDrawBusy),
        .enterSwap_o     (enterSwap),
        .enterClear_o    (enterClear),
        .swapPendNext_o  (swapPendNext),
        .clearPendNext_o (clearPendNext)
    );

    // Next-state logic. The sequence target is the back buffer, i.e. the
    // complement of the front buffer at the moment the sequence is entered.
    always_comb begin
        state_d      = state_q;
        front_d      = front_q;
        clearStart_d = 1'b0;
        timeout_d    = 1'b0;
        autoClearSet = 1'b0;
        case (state_q)
            IDLE: begin
                if (enterSwap) begin
                    state_d = front_q ? CHANGE_STATE0 : CHANGE_STATE1;
                end else if (enterClear) begin
                    state_d = front_q ? CLEAR_RESET_WAIT0 : CLEAR_RESET_WAIT1;
                end
            end
            CHANGE_STATE0: state_d = CHANGE_STATE0_LOAD;
            CHANGE_STATE1: state_d = CHANGE_STATE1_LOAD;
            CHANGE_STATE0_LOAD, CHANGE_STATE1_LOAD: begin
                if (iLoadDone) begin
                    front_d      = (state_q == CHANGE_STATE1_LOAD);
                    state_d      = IDLE;
                    autoClearSet = (AUTO_CLEAR != 0);
                end
            end
            CLEAR_RESET_WAIT0: begin
                state_d      = CLEAR_RESET_SLOT0;
                clearStart_d = 1'b1;
            end
            CLEAR_RESET_WAIT1: begin
                state_d      = CLEAR_RESET_SLOT1;
                clearStart_d = 1'b1;
            end
            CLEAR_RESET_SLOT0, CLEAR_RESET_SLOT1: begin
                if (iClearDone) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef FRAME_SWAP_TIMEOUT_EN
        // A completion arriving on the last allowed cycle still wins.
        inTimedState = (state_q == CHANGE_STATE0_LOAD) || (state_q == CHANGE_STATE1_LOAD) ||
                       (state_q == CLEAR_RESET_SLOT0)  || (state_q == CLEAR_RESET_SLOT1);
        if (inTimedState && (state_d == state_q) && (timer_q == TIMEOUT_LAST)) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
        end
        timer_d = (inTimedState && (state_d == state_q)) ? timer_q + 1'b1 : '0;
`endif

        grant_d = (state_d == IDLE) && !swapPendNext && !clearPendNext;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q      <= IDLE;
            front_q      <= 1'b0;
            grant_q      <= 1'b0;
            clearStart_q <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            front_q      <= front_d;
            grant_q      <= grant_d;
            clearStart_q <= clearStart_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

`ifdef FRAME_SWAP_TIMEOUT_EN
    always_ff @(posedge iClk) begin
        if (iReset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    assign oState      = state_q;
    assign oFrontBuf   = front_q;
    assign oDrawGrant  = grant_q;
    assign oClearStart = clearStart_q;
    assign oBusy       = busy_q;
    assign oTimeout    = timeout_q;

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_swap_ctrl
// Drives two controllers from the same inputs, one with AUTO_CLEAR=1 (A) and
// one with AUTO_CLEAR=0 (B), and compares every output each cycle against a
// sequence-level model. Directed scenarios come first, then random traffic.
// -----------------------------------------------------------------------------
module tb_frame_swap_ctrl;

    localparam int TO = 100;

    logic iClk = 1'b0;
    logic iReset = 1'b1;
    logic iSwapReq = 1'b0, iClearReq = 1'b0, iDrawBusy = 1'b0;
    logic iLoadDone = 1'b0, iClearDone = 1'b0;

    logic [4:0] aState, bState;
    logic aFront, aGrant, aStart, aBusy, aTimeout;
    logic bFront, bGrant, bStart, bBusy, bTimeout;

    int checks = 0;
    int errors = 0;

    // Model: per instance, which sequence runs (0 none, 1 swap, 2 clear),
    // whether its one-cycle arming phase is over, and its target buffer.
    int mSeq[2], mPhase[2], mTgt[2], mFront[2], mWait[2];
    bit mSwapP[2], mClearP[2], mJustReset[2], mStart[2], mTimeout[2];

    always #5 iClk = ~iClk;

    frame_swap_ctrl #(.AUTO_CLEAR(1), .TIMEOUT_CYCLES(TO)) dutA (
        .iClk(iClk), .iReset(iReset), .iSwapReq(iSwapReq), .iClearReq(iClearReq),
        .iDrawBusy(iDrawBusy), .iLoadDone(iLoadDone), .iClearDone(iClearDone),
        .oState(aState), .oFrontBuf(aFront), .oDrawGrant(aGrant),
        .oClearStart(aStart), .oBusy(aBusy), .oTimeout(aTimeout)
    );

    frame_swap_ctrl #(.AUTO_CLEAR(0), .TIMEOUT_CYCLES(TO)) dutB (
        .iClk(iClk), .iReset(iReset), .iSwapReq(iSwapReq), .iClearReq(iClearReq),
        .iDrawBusy(iDrawBusy), .iLoadDone(iLoadDone), .iClearDone(iClearDone),
        .oState(bState), .oFrontBuf(bFront), .oDrawGrant(bGrant),
        .oClearStart(bStart), .oBusy(bBusy), .oTimeout(bTimeout)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model of instance k by one clock edge with the given inputs.
    task automatic modelStep(input int k, input bit sw, input bit cl, input bit busy,
                             input bit ld, input bit cd, input bit rst, input bit autoClr);
        bit enterSwap, enterClear;
        mStart[k]   = 1'b0;
        mTimeout[k] = 1'b0;
        if (rst) begin
            mSeq[k] = 0; mPhase[k] = 0; mTgt[k] = 0; mFront[k] = 0; mWait[k] = 0;
            mSwapP[k] = 1'b0; mClearP[k] = 1'b0; mJustReset[k] = 1'b1;
            return;
        end
        mJustReset[k] = 1'b0;
        enterSwap  = (mSeq[k] == 0) && mSwapP[k] && !busy;
        enterClear = (mSeq[k] == 0) && mClearP[k] && !mSwapP[k] && !busy;
        mSwapP[k]  = sw | (mSwapP[k] & !enterSwap);
        mClearP[k] = cl | (mClearP[k] & !enterClear);
        if (enterSwap) begin
            mSeq[k] = 1; mPhase[k] = 0; mTgt[k] = 1 - mFront[k];
        end else if (enterClear) begin
            mSeq[k] = 2; mPhase[k] = 0; mTgt[k] = 1 - mFront[k];
        end else if (mSeq[k] != 0 && mPhase[k] == 0) begin
            mPhase[k] = 1; mWait[k] = 0;
            if (mSeq[k] == 2) mStart[k] = 1'b1;
        end else if (mSeq[k] == 1 && ld) begin
            mFront[k] = mTgt[k]; mSeq[k] = 0;
            if (autoClr) mClearP[k] = 1'b1;
        end else if (mSeq[k] == 2 && cd) begin
            mSeq[k] = 0;
`ifdef FRAME_SWAP_TIMEOUT_EN
        end else if (mSeq[k] != 0) begin
            if (mWait[k] == TO - 1) begin
                mSeq[k] = 0; mTimeout[k] = 1'b1;
            end else begin
                mWait[k]++;
            end
`endif
        end
    endtask

    task automatic checkDut(input int k);
        int expState;
        bit expGrant;
        expState = (mSeq[k] == 0) ? 0 :
                   (mSeq[k] == 1) ? 9 + 2*mTgt[k] + mPhase[k] : 13 + 2*mTgt[k] + mPhase[k];
        expGrant = !mJustReset[k] && mSeq[k] == 0 && !mSwapP[k] && !mClearP[k];
        checkOutput(k == 0 ? "A.state" : "B.state", k == 0 ? 32'(aState) : 32'(bState), 32'(expState));
        checkOutput(k == 0 ? "A.front" : "B.front", k == 0 ? 32'(aFront) : 32'(bFront), 32'(mFront[k]));
        checkOutput(k == 0 ? "A.grant" : "B.grant", k == 0 ? 32'(aGrant) : 32'(bGrant), 32'(expGrant));
        checkOutput(k == 0 ? "A.clrStart" : "B.clrStart", k == 0 ? 32'(aStart) : 32'(bStart), 32'(mStart[k]));
        checkOutput(k == 0 ? "A.busy" : "B.busy", k == 0 ? 32'(aBusy) : 32'(bBusy), 32'(mSeq[k] != 0));
        checkOutput(k == 0 ? "A.timeout" : "B.timeout", k == 0 ? 32'(aTimeout) : 32'(bTimeout), 32'(mTimeout[k]));
    endtask

    // Drive one cycle of inputs, clock, then compare both DUTs to the model.
    task automatic applyStimulus(input bit sw, input bit cl, input bit busy,
                                 input bit ld, input bit cd, input bit rst);
        iSwapReq = sw; iClearReq = cl; iDrawBusy = busy;
        iLoadDone = ld; iClearDone = cd; iReset = rst;
        @(posedge iClk);
        modelStep(0, sw, cl, busy, ld, cd, rst, 1'b1);
        modelStep(1, sw, cl, busy, ld, cd, rst, 1'b0);
        #1;
        checkDut(0);
        checkDut(1);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int waits;
        int n;
        bit busy;

        // Reset state and grant coming up one cycle later
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("rst.state", 32'(aState), 0);
        checkOutput("rst.grant", 32'(aGrant), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rst.grantUp", 32'(aGrant), 1);

        // Basic swap then auto clear on the new back buffer
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("t1.pendIdle", 32'(aState), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t1.arm", 32'(aState), 11);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t1.load", 32'(aState), 12);
        idleCycles(20);
        checkOutput("t1.hold", 32'(aState), 12);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t1.front", 32'(aFront), 1);
        checkOutput("t1.idle", 32'(aState), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t1.clrWait", 32'(aState), 13);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t1.clrSlot", 32'(aState), 14);
        checkOutput("t1.clrStart", 32'(aStart), 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t1.clrStartOnce", 32'(aStart), 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("t1.done", 32'(aState), 0);

        // Swap held off by a busy drawing engine
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("t2.grantDrop", 32'(aGrant), 0);
        for (int i = 0; i < 49; i++) applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t2.stillIdle", 32'(aState), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t2.enter", 32'(aState), 11);
        idleCycles(3);
        applyStimulus(0, 0, 0, 1, 0, 0);
        idleCycles(3);
        applyStimulus(0, 0, 0, 0, 1, 0);

        // Simultaneous swap and clear without auto clear (instance B)
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t3.swapFirst", 32'(bState), 11);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t3.load", 32'(bState), 12);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t3.front", 32'(bFront), 1);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, 0, 0, 0, i >= 3, 0);
            if (i == 0) checkOutput("t3.clrBuf0", 32'(bState), 13);
            if (bState == 13 || bState == 15) n++;
        end
        checkOutput("t3.clrOnce", 32'(n), 1);

        // Three clear pulses during the load merge into one clear
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        idleCycles(2);
        checkOutput("t4.load1", 32'(aState), 12);
        for (int i = 0; i < 6; i++) applyStimulus(0, (i % 2) == 0, 0, 0, 0, 0);
        checkOutput("t4.stillLoad", 32'(bState), 12);
        applyStimulus(0, 0, 0, 1, 0, 0);
        n = 0;
        waits = 0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, 0, 0, 0, i >= 3, 0);
            if (bState == 13 || bState == 15) n++;
            if (aState == 13 || aState == 15) waits++;
        end
        checkOutput("t4.B.clrOnce", 32'(n), 1);
        checkOutput("t4.A.clrOnce", 32'(waits), 1);

        // Reset in CLEAR_RESET_SLOT1
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t5.wait1", 32'(aState), 15);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t5.slot1", 32'(aState), 16);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("t5.state", 32'(aState), 0);
        checkOutput("t5.front", 32'(aFront), 0);
        checkOutput("t5.busy", 32'(aBusy), 0);
        checkOutput("t5.noStart", 32'(aStart), 0);
        idleCycles(2);

`ifdef FRAME_SWAP_TIMEOUT_EN
        // Watchdog abort of a load that never completes
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        idleCycles(2);
        n = 0;
        while (n < 2*TO && aTimeout !== 1'b1) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            n++;
        end
        checkOutput("t6.cycles", 32'(n), TO);
        checkOutput("t6.state", 32'(aState), 0);
        checkOutput("t6.front", 32'(aFront), 0);
        idleCycles(2);
`endif

        // Random traffic
        applyStimulus(0, 0, 0, 0, 0, 1);
        busy = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) busy = ~busy;
            applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, busy,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 299) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_swap_ctrl.md
Name: frame_swap_ctrl

Overview:
- Control FSM that sequences the double-buffered frame-store readout datapath: drives its 5-bit state code, waits on its done flag, and schedules clears of the back buffer.
- Arbitrates the two frame buffers between the drawing engine (writes the back buffer) and the readout/clear engines.
- Sits between the user-command logic and the readout datapath / clear engine.

Parameters:
- SCREEN_WIDTH, 320, pixels per row (timeout sizing only)
- SCREEN_HEIGHT, 240, rows per frame (timeout sizing only)
- AUTO_CLEAR, 1, 1 = automatically queue a clear of the new back buffer after every swap
- TIMEOUT_CYCLES, 2*SCREEN_WIDTH*SCREEN_HEIGHT+64, watchdog limit (used only with FRAME_SWAP_TIMEOUT_EN)

Ports:
- iClk  in  1  system clock
- iReset  in  1  synchronous, active-high reset
- iSwapReq  in  1  pulse: display the current back buffer
- iClearReq  in  1  pulse: clear the current back buffer
- iDrawBusy  in  1  drawing engine is mid-primitive
- iLoadDone  in  1  readout datapath finished a full frame
- iClearDone  in  1  clear engine finished
- oState  out  5  state code to readout datapath
- oFrontBuf  out  1  buffer currently displayed; back buffer = ~oFrontBuf
- oDrawGrant  out  1  drawing engine may start a new primitive
- oClearStart  out  1  one-cycle pulse starting the clear engine
- oBusy  out  1  FSM not in IDLE
- oTimeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Interface fixed: one clock iClk; iReset synchronous, active-high.
- All outputs registered. Reset values: oState=IDLE(0), oFrontBuf=0, oDrawGrant=0 for one cycle then 1, oClearStart=0, oBusy=0, oTimeout=0. Pending flags cleared.
- State codes:
  - IDLE=0
  - CHANGE_STATE0=9, CHANGE_STATE0_LOAD=10
  - CHANGE_STATE1=11, CHANGE_STATE1_LOAD=12
  - CLEAR_RESET_WAIT0=13, CLEAR_RESET_SLOT0=14
  - CLEAR_RESET_WAIT1=15, CLEAR_RESET_SLOT1=16
  - oState always equals the current state.
- Request latching:
  - iSwapReq/iClearReq set swap_pend/clear_pend in any state.
  - Repeats while pending merge into one.
  - A pending flag clears on the cycle its sequence is entered.
- oDrawGrant = (state==IDLE) && !swap_pend && !clear_pend. The drawing engine finishes its current primitive, then drops iDrawBusy.
- IDLE exit requires !iDrawBusy.
  - Swap has priority over clear when both are pending.
  - The transition occurs on the cycle after the condition holds.
- Swap sequence, target b = ~oFrontBuf:
  - CHANGE_STATEb for exactly 1 cycle (datapath arms its load).
  - Then CHANGE_STATEb_LOAD until iLoadDone=1.
  - On iLoadDone: oFrontBuf<=b and go to IDLE next cycle.
  - If AUTO_CLEAR=1, set clear_pend in the same cycle.
  - iLoadDone outside a LOAD state is ignored.
- Clear sequence, target c = ~oFrontBuf, evaluated at entry:
  - CLEAR_RESET_WAITc for 1 cycle.
  - Then CLEAR_RESET_SLOTc; oClearStart pulses on the first SLOT cycle only.
  - Wait for iClearDone, then go to IDLE.
  - iClearDone on the start cycle is accepted.
- Requests arriving mid-sequence stay pending and are served from IDLE afterwards, never preempting.
- iReset mid-sequence: next cycle IDLE, oFrontBuf=0, pending flags lost. Downstream engines are reset by the same reset.

Optional Feature:
- FRAME_SWAP_TIMEOUT_EN defined:
  - A counter runs in any LOAD or SLOT state and clears on state change.
  - At TIMEOUT_CYCLES it forces IDLE, pulses oTimeout, and leaves oFrontBuf unchanged.
  - That sequence's pending flag stays clear.
- Undefined: no counter; the FSM waits indefinitely; oTimeout is tied 0.

Decomposition:
- Shared package frame_pkg:
  - 5-bit state typedef and the nine state-code constants, shared with the readout datapath.
  - Default SCREEN_WIDTH/SCREEN_HEIGHT.
- One natural sub-module: frame_swap_req_latch (the two pending flags plus the merge/priority logic). FSM and watchdog stay in the top module.

Test Plan:
- Reset then iSwapReq pulse, iDrawBusy=0:
  - oState goes 0→11 (1 cycle)→12.
  - Hold 20 cycles, pulse iLoadDone → oFrontBuf=1, oState=0.
  - Then (AUTO_CLEAR) 13→14 with oClearStart for 1 cycle, on buffer 0.
- iSwapReq while iDrawBusy=1 for 50 cycles → oDrawGrant=0 immediately, oState stays 0, enters 11 on the cycle after iDrawBusy falls.
- iSwapReq and iClearReq on the same cycle, AUTO_CLEAR=0, oFrontBuf=0:
  - Swap runs first (11,12); after iLoadDone the clear targets buffer 0 (13,14).
  - The clear runs exactly once.
- iClearReq pulsed 3 times during CHANGE_STATE1_LOAD → exactly one clear sequence after return to IDLE.
- iReset asserted in CLEAR_RESET_SLOT1 → next cycle oState=0, oFrontBuf=0, oBusy=0, no oClearStart.
- With FRAME_SWAP_TIMEOUT_EN, TIMEOUT_CYCLES=100, iLoadDone never asserted → oTimeout pulses 100 cycles into state 12, oState=0, oFrontBuf unchanged.
